// File: rtl/tb_seq_pkg.sv
// Shared types and constants for the valid/ready stimulus/response sequencer.
package tb_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WARMUP,
      SEND,
      WAIT,
      DONE,
      ERR
   } seq_state_t;

   // Galois LFSR, right-shifting, polynomial x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int DEF_WARMUP_CYCLES  = 5;
   localparam int DEF_NUM_TXN        = 1024;
   localparam int DEF_CNT_W          = 16;
   localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/tb_seq_control_lfsr.sv
// 16-bit Galois LFSR producing the back-pressure bit; only instantiated when
// TB_SEQ_CONTROL_RAND_STALL_EN is defined.
module tb_lfsr16
   import tb_seq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   output logic stall
);

   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   assign stall = lfsr[0];

endmodule

// File: rtl/tb_seq_control.sv
// Stimulus/response sequencer: warm-up, NUM_TXN one-at-a-time transactions,
// per-transaction timeout and max-latency tracking. Define
// TB_SEQ_CONTROL_RAND_STALL_EN for pseudo-random result back-pressure.
//
// state  | meaning
// IDLE   | waiting for start, all outputs low
// WARMUP | idle interval before the first operand
// SEND   | ops_val high until the unit accepts operands
// WAIT   | res_rdy high until a result arrives or the timeout limit is hit
// DONE   | run complete, counters held, start restarts
// ERR    | timeout, sticky until rst
module tb_seq_control
   import tb_seq_pkg::*;
#(
   parameter int WARMUP_CYCLES  = DEF_WARMUP_CYCLES,
   parameter int NUM_TXN        = DEF_NUM_TXN,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             ops_val,
   input  logic             ops_rdy,
   input  logic             res_val,
   output logic             res_rdy,
   output logic             gen_en,
   output logic             chk_en,
   output logic [CNT_W-1:0] txn_cnt,
   output logic [CNT_W-1:0] lat_max,
   output logic             done,
   output logic             timeout_err
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] WARM_END = CNT_W'(WARMUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TXN_END  = CNT_W'(NUM_TXN);
   localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(TIMEOUT_CYCLES);
   // The start cycle itself is the first warm-up cycle, so a single cycle of
   // warm-up already lands on SEND right after start.
   localparam seq_state_t FIRST_STATE = (WARMUP_CYCLES <= 1) ? SEND : WARMUP;

   seq_state_t       state;
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] lat_cnt;
   logic [CNT_W-1:0] txn_nxt;
   logic [CNT_W-1:0] cyc_nxt;
   logic             stall_ok;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (x == CNT_MAX) ? x : x + CNT_ONE;
   endfunction

`ifdef TB_SEQ_CONTROL_RAND_STALL_EN
   logic stall;

   tb_lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .stall (stall)
   );

   assign stall_ok = ~stall;
`else
   assign stall_ok = 1'b1;
`endif

   assign ops_val     = (state == SEND);
   assign res_rdy     = (state == WAIT) & stall_ok;
   assign done        = (state == DONE);
   assign timeout_err = (state == ERR);
   assign gen_en      = ops_val & ops_rdy;
   assign chk_en      = res_val & res_rdy;

   assign txn_nxt = sat_inc(txn_cnt);
   assign cyc_nxt = sat_inc(cyc_cnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cyc_cnt <= '0;
         lat_cnt <= '0;
         txn_cnt <= '0;
         lat_max <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= FIRST_STATE;
                  cyc_cnt <= '0;
                  lat_cnt <= '0;
                  txn_cnt <= '0;
                  lat_max <= '0;
               end
            end
            WARMUP: begin
               cyc_cnt <= cyc_nxt;
               if (cyc_nxt == WARM_END) begin
                  state <= SEND;
               end
            end
            SEND: begin
               if (ops_rdy) begin
                  state   <= WAIT;
                  lat_cnt <= CNT_ONE;
               end
            end
            WAIT: begin
               // A transfer on the limit cycle still counts as a good transaction.
               if (chk_en) begin
                  txn_cnt <= txn_nxt;
                  if (lat_cnt > lat_max) begin
                     lat_max <= lat_cnt;
                  end
                  state <= (txn_nxt == TXN_END) ? DONE : SEND;
               end else if (lat_cnt == TMO_END) begin
                  state <= ERR;
               end else begin
                  lat_cnt <= sat_inc(lat_cnt);
               end
            end
            ERR: begin
               state <= ERR;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tb_seq_control.sv
// Self-checking bench for tb_seq_control: table-driven opening sequence plus
// randomized transactions checked against a transaction-level model.
module tb_tb_seq_control;

   localparam int W  = 5;
   localparam int N  = 4;
   localparam int T  = 8;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          ops_rdy;
   logic          res_val;
   logic          ops_val;
   logic          res_rdy;
   logic          gen_en;
   logic          chk_en;
   logic [CW-1:0] txn_cnt;
   logic [CW-1:0] lat_max;
   logic          done;
   logic          timeout_err;

   tb_seq_control #(
      .WARMUP_CYCLES  (W),
      .NUM_TXN        (N),
      .CNT_W          (CW),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .ops_val     (ops_val),
      .ops_rdy     (ops_rdy),
      .res_val     (res_val),
      .res_rdy     (res_rdy),
      .gen_en      (gen_en),
      .chk_en      (chk_en),
      .txn_cnt     (txn_cnt),
      .lat_max     (lat_max),
      .done        (done),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int m_txn;
   int m_lat_max;
   bit m_in_err;

   typedef struct {
      bit start;
      bit ops_rdy;
      bit res_val;
      bit e_ov;
      bit e_rr;
      bit e_gen;
   } vec_t;

   vec_t tbl[9];

`ifdef TB_SEQ_CONTROL_RAND_STALL_EN
   logic [15:0] m_lfsr;
   always @(posedge clk) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end
   function automatic bit stall_ok();
      return ~m_lfsr[0];
   endfunction
`else
   function automatic bit stall_ok();
      return 1'b1;
   endfunction
`endif

   task automatic chk_bit(input string name, input logic act, input bit exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chk_val(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input bit e_ov, input bit e_rr,
                           input bit e_gen, input bit e_chk, input bit e_done,
                           input bit e_err);
      chk_bit({tag, ".ops_val"}, ops_val, e_ov);
      chk_bit({tag, ".res_rdy"}, res_rdy, e_rr);
      chk_bit({tag, ".gen_en"}, gen_en, e_gen);
      chk_bit({tag, ".chk_en"}, chk_en, e_chk);
      chk_bit({tag, ".done"}, done, e_done);
      chk_bit({tag, ".timeout_err"}, timeout_err, e_err);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; ops_rdy = 1'b0; res_val = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk_outs("reset", 0, 0, 0, 0, 0, 0);
      chk_val("reset.txn_cnt", int'(txn_cnt), 0);
      chk_val("reset.lat_max", int'(lat_max), 0);
      m_txn = 0; m_lat_max = 0; m_in_err = 0;
   endtask

   // Drives the result side from latency lat0 on; result appears at res_dly.
   task automatic wait_result(input int lat0, input int res_dly);
      int lat;
      bit fin;
      bit er;
      lat = lat0;
      fin = 0;
      while (!fin) begin
         ops_rdy = 1'b0;
         start   = 1'($urandom_range(0, 1));
         res_val = (lat >= res_dly);
         #1;
         er = stall_ok();
         chk_outs($sformatf("wait.lat%0d", lat), 0, er, 0, res_val & er, 0, 0);
         if (res_val && er) begin
            m_txn++;
            if (lat > m_lat_max) m_lat_max = lat;
            tick();
            fin = 1; start = 1'b0; res_val = 1'b0;
            #1;
            chk_val("xfer.txn_cnt", int'(txn_cnt), m_txn);
            chk_val("xfer.lat_max", int'(lat_max), m_lat_max);
            chk_outs("xfer", m_txn != N, 0, 0, 0, m_txn == N, 0);
         end else if (lat == T) begin
            tick();
            fin = 1; start = 1'b0; res_val = 1'b0;
            #1;
            chk_outs("timeout", 0, 0, 0, 0, 0, 1);
            m_in_err = 1;
         end else begin
            lat++;
            tick();
         end
      end
   endtask

   task automatic run_txn(input int rdy_dly, input int res_dly);
      for (int i = 0; i <= rdy_dly; i++) begin
         start   = 1'($urandom_range(0, 1));
         res_val = 1'($urandom_range(0, 1));
         ops_rdy = (i == rdy_dly);
         #1;
         chk_outs("send", 1, 0, i == rdy_dly, 0, 0, 0);
         tick();
      end
      start = 1'b0;
      wait_result(1, res_dly);
   endtask

   task automatic start_run();
      if (m_in_err) do_reset();
      start = 1'b1; ops_rdy = 1'b0; res_val = 1'b0;
      #1;
      chk_outs("start", 0, 0, 0, 0, m_txn == N, 0);
      tick();
      m_txn = 0; m_lat_max = 0;
      for (int i = 1; i < W; i++) begin
         start   = 1'($urandom_range(0, 1));
         ops_rdy = 1'($urandom_range(0, 1));
         #1;
         chk_outs("warmup", 0, 0, 0, 0, 0, 0);
         if (i == 1) begin
            chk_val("restart.txn_cnt", int'(txn_cnt), 0);
            chk_val("restart.lat_max", int'(lat_max), 0);
         end
         tick();
      end
      start = 1'b0; ops_rdy = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ops_rdy = 1'b0; res_val = 1'b0;
      do_reset();

      // start, 4 warm-up cycles, SEND hold, operand transfer, first WAIT cycles
      tbl[0] = '{1, 0, 0, 0, 0, 0};
      tbl[1] = '{0, 0, 0, 0, 0, 0};
      tbl[2] = '{0, 1, 0, 0, 0, 0};
      tbl[3] = '{1, 0, 0, 0, 0, 0};
      tbl[4] = '{0, 0, 1, 0, 0, 0};
      tbl[5] = '{0, 0, 1, 1, 0, 0};
      tbl[6] = '{0, 1, 0, 1, 0, 1};
      tbl[7] = '{1, 0, 0, 0, 1, 0};
      tbl[8] = '{0, 0, 0, 0, 1, 0};
      for (int i = 0; i < 9; i++) begin
         bit er;
         start = tbl[i].start; ops_rdy = tbl[i].ops_rdy; res_val = tbl[i].res_val;
         #1;
         er = tbl[i].e_rr & stall_ok();
         chk_outs($sformatf("vec%0d", i), tbl[i].e_ov, er, tbl[i].e_gen,
                  tbl[i].res_val & er, 0, 0);
         tick();
      end
      start = 1'b0; ops_rdy = 1'b0; res_val = 1'b0;

      // normal run: result 3 cycles after every operand transfer
      wait_result(3, 3);
      for (int k = 1; k < N; k++) begin
         if (!m_in_err) run_txn(0, 3);
      end
      for (int i = 0; i < 2; i++) begin
         ops_rdy = 1'b1; res_val = 1'b1;
         #1;
         chk_outs("hold", 0, 0, 0, 0, !m_in_err && m_txn == N, m_in_err);
         chk_val("hold.txn_cnt", int'(txn_cnt), m_txn);
         chk_val("hold.lat_max", int'(lat_max), m_lat_max);
         tick();
      end
      ops_rdy = 1'b0; res_val = 1'b0;

      // restart from DONE with random delays; second transaction on the limit
      start_run();
      for (int k = 0; k < N; k++) begin
         if (!m_in_err)
            run_txn($urandom_range(0, 3), (k == 1) ? T : $urandom_range(1, T));
      end

      // timeout: result never arrives, then start must be ignored
      start_run();
      run_txn(0, T + 1);
      for (int i = 0; i < 3; i++) begin
         start = 1'b1; ops_rdy = 1'b1; res_val = 1'b1;
         #1;
         chk_outs("err_hold", 0, 0, 0, 0, 0, 1);
         tick();
      end
      start = 1'b0; ops_rdy = 1'b0; res_val = 1'b0;

      // reset in the middle of WAIT aborts the run
      start_run();
      run_txn(0, 2);
      if (!m_in_err) begin
         ops_rdy = 1'b1;
         #1;
         chk_outs("pre_rst", 1, 0, 1, 0, 0, 0);
         tick();
         ops_rdy = 1'b0; res_val = 1'b1; rst = 1'b1;
         tick();
         rst = 1'b0; res_val = 1'b0;
         #1;
         chk_outs("rst_mid", 0, 0, 0, 0, 0, 0);
         chk_val("rst_mid.txn_cnt", int'(txn_cnt), 0);
         chk_val("rst_mid.lat_max", int'(lat_max), 0);
         tick();
         #1;
         chk_outs("rst_idle", 0, 0, 0, 0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
